// File: rtl/axis_out_pkg.sv
// Shared helpers for the output serializer: derivation of the number of words
// per wide input beat and the number of narrow sub-beats each one is split into.
// No ports; imported by axis_out_serializer.
package axis_out_pkg;

    // Accumulator words carried by one wide input beat.
    function automatic int unsigned calc_in_words(input int unsigned cores,
                                                  input int unsigned units);
        return cores * units;
    endfunction

    // Narrow output beats per wide input beat.
    function automatic int unsigned calc_r(input int unsigned in_words,
                                           input int unsigned out_words);
        return in_words / out_words;
    endfunction

    // The wide beat must split into a whole number of narrow beats.
    function automatic bit words_divisible(input int unsigned in_words,
                                           input int unsigned out_words);
        return (out_words != 0) && ((in_words % out_words) == 0);
    endfunction

endpackage

// File: rtl/axis_out_serializer_if.sv
// AXI-Stream bundle shared by the wide input side and the narrow output side of
// the serializer.
//   tdata  : payload, DataWidth bits (lowest word index in the MSBs)
//   tkeep  : byte enables, DataWidth/8 bits
//   tuser  : sideband, UserWidth bits
//   tvalid / tready / tlast : handshake and packet boundary
// Modports: master drives the stream, slave receives it.
interface axis_out_serializer_if #(
    parameter int unsigned DataWidth = 64,
    parameter int unsigned UserWidth = 1
);
    logic [DataWidth-1:0]   tdata;
    logic [DataWidth/8-1:0] tkeep;
    logic [UserWidth-1:0]   tuser;
    logic                   tvalid;
    logic                   tready;
    logic                   tlast;

    modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_out_serializer.sv
// Serializes one wide accumulator beat (CORES*UNITS words) into R narrow beats of
// OUT_WORDS words each, preserving word order, tlast and backpressure.
//   aclk    : clock, rising edge
//   areset  : synchronous active-high reset
//   s_axis  : wide input stream (slave), word 0 in the MSBs
//   m_axis  : narrow output stream (master), lowest word index in the MSBs
// Optional build macro AXIS_OUT_DROP_CONFIG_EN: drop the leading config beats of
// every packet (count selected by s_axis.tuser[I_IS_1X1]) instead of forwarding them.
module axis_out_serializer
    import axis_out_pkg::*;
#(
    parameter int unsigned WORD_WIDTH_ACC     = 32,
    parameter int unsigned CORES              = 2,
    parameter int unsigned UNITS              = 4,
    parameter int unsigned OUT_WORDS          = 2,
    parameter int unsigned TUSER_WIDTH        = 7,
    parameter int unsigned I_IS_1X1           = 5,
    parameter int unsigned BEATS_CONFIG_3X3_1 = 20,
    parameter int unsigned BEATS_CONFIG_1X1_1 = 12
) (
    input  logic                  aclk,
    input  logic                  areset,
    axis_out_serializer_if.slave  s_axis,
    axis_out_serializer_if.master m_axis
);

    localparam int unsigned InWords        = calc_in_words(CORES, UNITS);
    localparam int unsigned R              = calc_r(InWords, OUT_WORDS);
    localparam bit          WordsDivisible = words_divisible(InWords, OUT_WORDS);
    localparam int unsigned InW            = WORD_WIDTH_ACC * InWords;
    localparam int unsigned OutW           = WORD_WIDTH_ACC * OUT_WORDS;
    localparam int unsigned PhW            = (R > 1) ? $clog2(R) : 1;
    localparam logic [PhW-1:0] PhLast      = PhW'(R - 1);

    if (!WordsDivisible) begin : g_bad_ratio
        $error("CORES*UNITS must be a multiple of OUT_WORDS");
    end

    logic [InW-1:0] buf_q, buf_d;
    logic           full_q, full_d;
    logic [PhW-1:0] ph_q, ph_d;
    logic           last_q, last_d;

    logic ph_last, out_fire, s_ready, accept, load, drop_beat;
    logic [OutW-1:0] sub_beat [R];

    assign ph_last  = (ph_q == PhLast);
    assign out_fire = full_q && m_axis.tready;
    // The final sub-beat and the next load share a cycle for full throughput.
    assign s_ready  = !areset && (!full_q || (ph_last && m_axis.tready));
    assign accept   = s_axis.tvalid && s_ready;
    assign load     = accept && !drop_beat;

    always_comb begin
        buf_d  = buf_q;
        full_d = full_q;
        ph_d   = ph_q;
        last_d = last_q;
        if (out_fire) begin
            if (!ph_last) ph_d = ph_q + PhW'(1);
            else          full_d = 1'b0;
        end
        // A load in the drain cycle overrides the clear above.
        if (load) begin
            buf_d  = s_axis.tdata;
            full_d = 1'b1;
            ph_d   = '0;
            last_d = s_axis.tlast;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            full_q <= 1'b0;
            ph_q   <= '0;
            last_q <= 1'b0;
        end else begin
            full_q <= full_d;
            ph_q   <= ph_d;
            last_q <= last_d;
        end
    end

    // Payload needs no reset; full_q qualifies it.
    always_ff @(posedge aclk) begin
        buf_q <= buf_d;
    end

    for (genvar i = 0; i < R; i++) begin : g_sub
        assign sub_beat[i] = buf_q[(R-1-i)*OutW +: OutW];
    end

    assign s_axis.tready = s_ready;
    assign m_axis.tdata  = sub_beat[ph_q];
    assign m_axis.tvalid = full_q;
    assign m_axis.tlast  = full_q && last_q && ph_last;
    assign m_axis.tkeep  = '1;
    assign m_axis.tuser  = '0;

    logic unused_skeep;
    assign unused_skeep = ^s_axis.tkeep;

`ifdef AXIS_OUT_DROP_CONFIG_EN
    localparam int unsigned CfgMax = (BEATS_CONFIG_3X3_1 > BEATS_CONFIG_1X1_1) ?
                                     BEATS_CONFIG_3X3_1 : BEATS_CONFIG_1X1_1;
    localparam int unsigned CntW   = $clog2(CfgMax + 2);

    logic [CntW-1:0] cnt_q, cnt_d, n_q, n_d, n_cur;

    always_comb begin
        // The first beat of a packet picks its own config length from tuser.
        n_cur     = (cnt_q == '0) ? (s_axis.tuser[I_IS_1X1] ? CntW'(BEATS_CONFIG_1X1_1)
                                                            : CntW'(BEATS_CONFIG_3X3_1))
                                  : n_q;
        drop_beat = (cnt_q <= n_cur);
        cnt_d     = cnt_q;
        n_d       = n_q;
        if (accept) begin
            if (cnt_q == '0) n_d = n_cur;
            // Count saturates at n+1 once the config region is passed.
            if (s_axis.tlast)   cnt_d = '0;
            else if (drop_beat) cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            cnt_q <= '0;
            n_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            n_q   <= n_d;
        end
    end

    logic [31:0] unused_cfg;
    assign unused_cfg = 32'(TUSER_WIDTH);
`else
    assign drop_beat = 1'b0;

    logic unused_tuser;
    assign unused_tuser = ^s_axis.tuser;

    logic [31:0] unused_cfg;
    assign unused_cfg = 32'(TUSER_WIDTH + I_IS_1X1 + BEATS_CONFIG_3X3_1 + BEATS_CONFIG_1X1_1);
`endif

endmodule

// File: tb/tb_axis_out_serializer.sv
module tb_axis_out_serializer;
    localparam int unsigned InW  = 256;
    localparam int unsigned OutW = 64;
    localparam int unsigned TW   = 7;

    logic aclk = 1'b0;
    logic areset;
    always #5 aclk = ~aclk;

    axis_out_serializer_if #(.DataWidth(InW),  .UserWidth(TW)) s_if ();
    axis_out_serializer_if #(.DataWidth(OutW), .UserWidth(1))  m_if ();

    axis_out_serializer #(
        .WORD_WIDTH_ACC(32), .CORES(2), .UNITS(4), .OUT_WORDS(2), .TUSER_WIDTH(TW),
        .I_IS_1X1(5), .BEATS_CONFIG_3X3_1(20), .BEATS_CONFIG_1X1_1(12)
    ) dut (
        .aclk   (aclk),
        .areset (areset),
        .s_axis (s_if),
        .m_axis (m_if)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [InW-1:0] mk_beat(input int unsigned base);
        logic [InW-1:0] d;
        for (int i = 0; i < 8; i++) d[InW-1-32*i -: 32] = base + i;
        return d;
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [31:0] w0();
        return m_if.tdata[63:32];
    endfunction

    function automatic logic [31:0] w1();
        return m_if.tdata[31:0];
    endfunction

    typedef struct {
        bit          s_valid;
        bit          s_last;
        int unsigned s_beat;
        bit          m_ready;
        bit          e_s_ready;
        bit          e_m_valid;
        bit          e_m_last;
        int unsigned e_w0;
        int unsigned e_w1;
    } vec_t;

    typedef struct {
        int unsigned w0;
        int unsigned w1;
        bit          last;
    } out_t;

    // Stream n_pkts packets of pkt_len beats with m_ready high; beat g carries words 8g+i.
    task automatic run_stream(input string tag, input int n_pkts, input int pkt_len,
                              input bit is1x1, input int unsigned g0);
        out_t expq[$];
        int   sent  = 0;
        int   got   = 0;
        int   cyc   = 0;
        int   total = n_pkts * pkt_len;
        int   nlast = is1x1 ? 12 : 20;
        for (int p = 0; p < n_pkts; p++) begin
            for (int k = 0; k < pkt_len; k++) begin
                int unsigned g = g0 + p * pkt_len + k;
                bit dropped = 1'b0;
`ifdef AXIS_OUT_DROP_CONFIG_EN
                dropped = (k <= nlast);
`endif
                if (!dropped) begin
                    for (int s = 0; s < 4; s++) begin
                        out_t o;
                        o.w0   = 8 * g + 2 * s;
                        o.w1   = 8 * g + 2 * s + 1;
                        o.last = (k == pkt_len - 1) && (s == 3);
                        expq.push_back(o);
                    end
                end
            end
        end
        m_if.tready = 1'b1;
        while ((sent < total || got < expq.size()) && cyc < total * 5 + 50) begin
            s_if.tvalid   = (sent < total);
            s_if.tdata    = mk_beat(8 * (g0 + sent));
            s_if.tlast    = ((sent % pkt_len) == pkt_len - 1);
            s_if.tuser    = '0;
            s_if.tuser[5] = is1x1;
            #2;
            if (m_if.tvalid) begin
                if (got < expq.size()) begin
                    check({tag, "_w0"},   w0(),        expq[got].w0);
                    check({tag, "_w1"},   w1(),        expq[got].w1);
                    check({tag, "_last"}, m_if.tlast,  expq[got].last);
                end else begin
                    check({tag, "_extra"}, got, expq.size());
                end
                got++;
            end
            if (s_if.tvalid && s_if.tready) sent++;
            tick();
            cyc++;
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = '0;
        check({tag, "_sent"},  sent, total);
        check({tag, "_count"}, got,  expq.size());
        for (int i = 0; i < 3; i++) begin
            #2;
            check({tag, "_idle"}, m_if.tvalid, 1'b0);
            tick();
        end
    endtask

    vec_t vecs[14];

    initial begin
        areset      = 1'b1;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '1;
        s_if.tuser  = '0;
        m_if.tready = 1'b0;
        tick();
        tick();
        #2;
        check("rst_s_ready", s_if.tready, 1'b0);
        check("rst_m_valid", m_if.tvalid, 1'b0);
        check("rst_m_last",  m_if.tlast,  1'b0);
        areset = 1'b0;
        tick();

`ifndef AXIS_OUT_DROP_CONFIG_EN
        // Continuous stream: 3 beats, tlast on the third, sink always ready.
        for (int c = 0; c < 14; c++) begin
            vecs[c].s_valid   = (c <= 8);
            vecs[c].s_beat    = (c == 0) ? 0 : (c <= 4) ? 1 : 2;
            vecs[c].s_last    = vecs[c].s_valid && (vecs[c].s_beat == 2);
            vecs[c].m_ready   = 1'b1;
            vecs[c].e_s_ready = (c == 0) || (c == 4) || (c == 8) || (c == 12) || (c == 13);
            vecs[c].e_m_valid = (c >= 1) && (c <= 12);
            vecs[c].e_m_last  = (c == 12);
            vecs[c].e_w0      = 2 * (c - 1);
            vecs[c].e_w1      = 2 * (c - 1) + 1;
        end
        for (int c = 0; c < 14; c++) begin
            s_if.tvalid = vecs[c].s_valid;
            s_if.tdata  = mk_beat(8 * vecs[c].s_beat);
            s_if.tlast  = vecs[c].s_last;
            m_if.tready = vecs[c].m_ready;
            #2;
            check("vec_s_ready", s_if.tready, vecs[c].e_s_ready);
            check("vec_m_valid", m_if.tvalid, vecs[c].e_m_valid);
            if (vecs[c].e_m_valid) begin
                check("vec_w0",    w0(),       vecs[c].e_w0);
                check("vec_w1",    w1(),       vecs[c].e_w1);
                check("vec_last",  m_if.tlast, vecs[c].e_m_last);
                check("vec_tkeep", m_if.tkeep, 8'hff);
            end
            tick();
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;

        // Stall on the final sub-beat: s_ready must follow m_ready there.
        s_if.tvalid = 1'b1;
        s_if.tdata  = mk_beat(100);
        s_if.tlast  = 1'b1;
        m_if.tready = 1'b0;
        #2;
        check("stall_load_ready", s_if.tready, 1'b1);
        tick();
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #2;
            check("stall_w0", w0(), 100 + 2 * k);
            tick();
        end
        m_if.tready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #2;
            check("stall_s_ready", s_if.tready, 1'b0);
            check("stall_valid",   m_if.tvalid, 1'b1);
            check("stall_last",    m_if.tlast,  1'b1);
            check("stall_w0_hold", w0(),        106);
            tick();
        end
        m_if.tready = 1'b1;
        #2;
        check("stall_release_ready", s_if.tready, 1'b1);
        tick();
        #2;
        check("stall_empty", m_if.tvalid, 1'b0);
        tick();

        // Reset at ph=2 discards the partial beat.
        s_if.tvalid = 1'b1;
        s_if.tdata  = mk_beat(1600);
        m_if.tready = 1'b0;
        #2;
        tick();
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #2;
            check("rstmid_w0", w0(), 1600 + 2 * k);
            if (k < 2) tick();
        end
        areset = 1'b1;
        #1;
        check("rstmid_s_ready", s_if.tready, 1'b0);
        tick();
        #2;
        check("rstmid_valid", m_if.tvalid, 1'b0);
        check("rstmid_last",  m_if.tlast,  1'b0);
        areset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            #2;
            check("rstmid_no_out", m_if.tvalid, 1'b0);
        end
        tick();
        s_if.tvalid = 1'b1;
        s_if.tdata  = mk_beat(2400);
        s_if.tlast  = 1'b1;
        #2;
        check("rstmid_new_ready", s_if.tready, 1'b1);
        tick();
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        #2;
        check("rstmid_new_valid", m_if.tvalid, 1'b1);
        check("rstmid_new_w0",    w0(),        2400);
        for (int k = 0; k < 4; k++) tick();

        // Random backpressure at ~30% ready over 100 beats.
        begin
            int unsigned    b = 0;
            int unsigned    j = 0;
            int             cyc = 0;
            bit             prev_stall = 1'b0;
            logic [OutW-1:0] prev_data = '0;
            logic           prev_last = 1'b0;
            while (j < 400 && cyc < 4000) begin
                s_if.tvalid = (b < 100);
                s_if.tdata  = mk_beat(8 * b);
                s_if.tlast  = ((b % 10) == 9);
                m_if.tready = ($urandom_range(0, 99) < 30);
                #2;
                if (prev_stall) begin
                    check("rand_hold_valid", m_if.tvalid, 1'b1);
                    check("rand_hold_data",  m_if.tdata,  prev_data);
                    check("rand_hold_last",  m_if.tlast,  prev_last);
                end
                if (m_if.tvalid && m_if.tready) begin
                    check("rand_w0",   w0(),       2 * j);
                    check("rand_w1",   w1(),       2 * j + 1);
                    check("rand_last", m_if.tlast, ((j % 4) == 3) && (((j / 4) % 10) == 9));
                    j++;
                end
                prev_stall = m_if.tvalid && !m_if.tready;
                prev_data  = m_if.tdata;
                prev_last  = m_if.tlast;
                if (s_if.tvalid && s_if.tready) b++;
                tick();
                cyc++;
            end
            s_if.tvalid = 1'b0;
            s_if.tlast  = 1'b0;
            check("rand_count", j, 400);
            m_if.tready = 1'b1;
            for (int k = 0; k < 4; k++) tick();
        end
`endif

        // 3x3 packet: 21 config + 5 data beats.
        run_stream("pkt3x3", 1, 26, 1'b0, 3000);
        // Two back-to-back 1x1 packets: 13 config + 2 data beats each.
        run_stream("pkt1x1", 2, 15, 1'b1, 4000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/axis_out_serializer.md
# axis_out_serializer

Downstream of `axis_accelerator`. Accepts the wide output beat (`CORES*UNITS` accumulator words of `WORD_WIDTH_ACC` bits) and serializes it into narrower beats of `OUT_WORDS` words for the output DMA. Preserves word order, packet boundaries and backpressure in both directions. Optionally strips the per-packet config beats before they reach memory.

## Interface

Parameters:
- `WORD_WIDTH_ACC`, 32: bits per accumulator word.
- `CORES`, 2: cores per input beat (`MEMBERS*COPIES*GROUPS`).
- `UNITS`, 4: units per core.
- `OUT_WORDS`, 2: words per output beat. `CORES*UNITS` must be an integer multiple of it.
- `TUSER_WIDTH`, 7: input tuser width (`TUSER_WIDTH_LRELU_IN`).
- `I_IS_1X1`, 5: tuser bit flagging a 1x1 layer.
- `BEATS_CONFIG_3X3_1`, 20: config beats minus one, 3x3 layer.
- `BEATS_CONFIG_1X1_1`, 12: config beats minus one, 1x1 layer.

Derived values:
- `IN_WORDS = CORES*UNITS`
- `R = IN_WORDS/OUT_WORDS`

Ports:
- `aclk` in 1: clock, all logic on the rising edge.
- `areset` in 1: synchronous, active-high reset.
- `s_axis_tdata` in `WORD_WIDTH_ACC*IN_WORDS`: input beat. Word 0 (core 0, unit 0) is in the MSBs.
- `s_axis_tvalid` in 1 / `s_axis_tready` out 1 / `s_axis_tlast` in 1: input handshake.
- `s_axis_tuser` in `TUSER_WIDTH`: input sideband.
- `m_axis_tdata` out `WORD_WIDTH_ACC*OUT_WORDS`: output beat, lowest word index in the MSBs.
- `m_axis_tvalid` out 1 / `m_axis_tready` in 1 / `m_axis_tlast` out 1: output handshake.
- `m_axis_tkeep` out `WORD_WIDTH_ACC*OUT_WORDS/8`: always all-ones while valid.

## Operation

Holding register and phase counter:
- A holding register `buf` (`IN_WORDS` words) has a `full` flag and a phase counter `ph` (0..R-1).
- An input beat is accepted when `s_axis_tvalid && s_axis_tready`. On accept: load `buf`, set `full`, set `ph=0`, and latch `s_axis_tlast` into `last_q`.

Output driving:
- `m_axis_tdata` = words `ph*OUT_WORDS .. ph*OUT_WORDS+OUT_WORDS-1` of `buf`, taken directly from the register with no extra pipeline.
- `m_axis_tvalid = full`.
- `m_axis_tlast = full && last_q && ph==R-1`.

Output consumption:
- On `m_axis_tvalid && m_axis_tready`:
  - If `ph<R-1`, increment `ph`.
  - Otherwise, the input beat is fully drained.
- `s_axis_tready = !full || (ph==R-1 && m_axis_tready)`. The last sub-beat and the next load happen in the same cycle, so the block runs at full throughput of one input beat per R cycles.
- Simultaneous drain and accept: the load wins. `full` stays 1 and `ph` goes to 0.
- Drain with no accept: `full` goes to 0.
- `R==1` degenerates to a one-register pipeline stage, still at full throughput.

Stall and reset:
- While `m_axis_tready` is low, `m_axis_tdata`, `m_axis_tlast` and `m_axis_tvalid` hold stable. This is the AXI-Stream rule.
- `areset`: `full=0`, `ph=0`, `last_q=0`, and the drop counter (below) goes to 0.
- Outputs under reset: `m_axis_tvalid=0`, `m_axis_tlast=0`, `s_axis_tready=0`.
- A reset asserted mid-beat discards the partially drained beat. No output is produced for it after reset releases.

## Timing

- Latency: input accepted at edge N → first sub-beat valid in the cycle after edge N.
- Word k of an input beat appears in output beat `k/OUT_WORDS`.
- Sustained rate: `IN_WORDS` words per R cycles with `m_axis_tready` held high.
- `s_axis_tready` depends combinationally on `m_axis_tready`. This is the only combinational input→output path.

## Configuration

- Macro `AXIS_OUT_DROP_CONFIG_EN`.
- Defined:
  - A per-packet beat counter `cnt` counts accepted input beats and clears after a `tlast` beat.
  - On the first beat of each packet (`cnt==0`), latch `n = s_axis_tuser[I_IS_1X1] ? BEATS_CONFIG_1X1_1 : BEATS_CONFIG_3X3_1`.
  - Input beats with `cnt<=n` are accepted but never loaded into `buf`.
  - `s_axis_tready` is forced to 1 for these beats only while `!full || drain`.
  - A packet whose `tlast` falls inside the dropped region produces no output and clears `cnt`.
- Undefined:
  - Every input beat is serialized, and `s_axis_tuser` is unused.
  - `cnt` and its logic are not instantiated.

## Structure

- Shared package `axis_out_pkg`: `IN_WORDS`/`R` derivation helpers and a `localparam` check that `IN_WORDS % OUT_WORDS == 0`, triggering `$error` at elaboration when it fails.
- Tuser indices stay in the top-level parameters, consistent with the accelerator.
- No sub-module: a single flat module. The drop counter lives under `ifdef` in the same file.

## Test plan

- **Continuous stream, R=4:** 3 beats with words 0..7 = 8b+i, `tlast` on beat 3, `m_axis_tready=1` → 12 output beats carrying `{8b+2j, 8b+2j+1}`. `s_axis_tready` pulses once per 4 cycles. `m_axis_tlast` is high on output beat 12 only.
- **Random backpressure:** `m_axis_tready` at 30% duty for 100 beats → output word sequence identical to input, and data stays stable whenever `tvalid && !tready`.
- **Reset mid-beat:** assert `areset` at `ph=2` → next cycle `m_axis_tvalid=0`. The following beat starts at word 0.
- **Drop config, 3x3** (with macro): packet of 21 config + 5 data beats, `tuser[5]=0` → exactly 20 output beats from the 5 data beats, `tlast` on the 20th.
- **Drop config, 1x1** (with macro): `tuser[5]=1`, 13 config + 2 data beats, then an immediate second packet → 8 + 8 output beats, and the counter restarts correctly.
- **Without macro:** same 26-beat packet → 104 output beats.
